ring_osc_sweep_sequencer: RTL

- Automates ring-oscillator measurements on instrumented_adder_kogge; sits between the LA control bits and the adder instance.
- Drives the adder's loop and counter controls to sweep the ring through each enabled adder bit.
- For each bit: runs one integration window, then captures ring_osc_counter_out into a result bank.
- Tracks the fastest (maximum-count) bit, so firmware issues one start and reads results afterwards.

---
 rtl/ring_osc_sweep_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ring_osc_sweep_sequencer.sv
// rtl/ring_osc_sweep_sequencer.sv - ring-oscillator sweep sequencer for instrumented_adder_kogge
// Steps the ring through each enabled adder bit, times one integration window per bit and banks the counts.
module ring_osc_sweep_sequencer #(
  parameter int NUM_BITS       = 8,
  parameter int COUNT_W        = 32,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_MARGIN = 16,
  localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [NUM_BITS-1:0] sweep_mask,
  input  logic [31:0]         integration_time,
  input  logic                adder_done,
  input  logic [COUNT_W-1:0]  ring_count,
  output logic                adder_reset,
  output logic                stop_b,
  output logic                counter_enable,
  output logic                counter_load,
  output logic [NUM_BITS-1:0] a_input_ring_bit_b,
  output logic [NUM_BITS-1:0] s_output_bit_b,
  output logic [31:0]         integration_time_out,
  output logic                busy,
  output logic                sweep_done,
  output logic                aborted,
  input  logic [IDX_W-1:0]    rd_addr,
  output logic [COUNT_W-1:0]  rd_data,
  output logic [NUM_BITS-1:0] timeout_flags,
  output logic [COUNT_W-1:0]  max_count,
  output logic [IDX_W-1:0]    max_index
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_STOP, S_CAPTURE, S_NEXT, S_FINISH
  } state_t;

  localparam logic [NUM_BITS-1:0] ALL_ONES = {NUM_BITS{1'b1}};

  state_t              state;
  logic [NUM_BITS-1:0] mask_q;
  logic                has_bits;
  logic [IDX_W-1:0]    cur_idx;
  logic [15:0]         phase_cnt;
  logic [32:0]         watchdog;
  logic [COUNT_W-1:0]  results [NUM_BITS];

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [IDX_W:0] find_set(input logic [NUM_BITS-1:0] m, input int from);
    find_set = '0;
    for (int j = NUM_BITS - 1; j >= 0; j--) begin
      if (m[j] && (j >= from)) find_set = {1'b1, IDX_W'(j)};
    end
  endfunction

  logic [IDX_W:0]      first_hit;
  logic [IDX_W:0]      next_hit;
  logic [32:0]         wd_inc;
  logic [32:0]         wd_limit;
  logic [NUM_BITS-1:0] sel_b;

  assign first_hit = find_set(sweep_mask, 0);
  assign next_hit  = find_set(mask_q, int'(cur_idx) + 1);
  assign wd_inc    = watchdog + 33'd1;
  assign wd_limit  = {1'b0, integration_time_out} + 33'(TIMEOUT_MARGIN);
  assign sel_b     = ~(NUM_BITS'(1) << cur_idx);
  assign rd_data   = results[rd_addr];
  assign s_output_bit_b = a_input_ring_bit_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= S_IDLE;
      mask_q               <= '0;
      has_bits             <= 1'b0;
      cur_idx              <= '0;
      phase_cnt            <= '0;
      watchdog             <= '0;
      for (int i = 0; i < NUM_BITS; i++) results[i] <= '0;
      adder_reset          <= 1'b1;
      stop_b               <= 1'b0;
      counter_enable       <= 1'b0;
      counter_load         <= 1'b0;
      a_input_ring_bit_b   <= ALL_ONES;
      integration_time_out <= '0;
      busy                 <= 1'b0;
      sweep_done           <= 1'b0;
      aborted              <= 1'b0;
      timeout_flags        <= '0;
      max_count            <= '0;
      max_index            <= '0;
    end else if (abort && (state != S_IDLE)) begin
      state              <= S_IDLE;
      adder_reset        <= 1'b0;
      stop_b             <= 1'b0;
      counter_enable     <= 1'b0;
      counter_load       <= 1'b0;
      a_input_ring_bit_b <= ALL_ONES;
      busy               <= 1'b0;
      sweep_done         <= 1'b0;
      aborted            <= 1'b1;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        S_IDLE: begin
          adder_reset <= 1'b0;
          if (start) begin
            integration_time_out <= integration_time;
            mask_q               <= sweep_mask;
            has_bits             <= first_hit[IDX_W];
            cur_idx              <= first_hit[IDX_W-1:0];
            for (int i = 0; i < NUM_BITS; i++) results[i] <= '0;
            timeout_flags        <= '0;
            max_count            <= '0;
            max_index            <= '0;
            aborted              <= 1'b0;
            busy                 <= 1'b1;
            adder_reset          <= 1'b1;
            phase_cnt            <= '0;
            state                <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          phase_cnt <= phase_cnt + 16'd1;
          if (phase_cnt == 16'd1) begin
            adder_reset <= 1'b0;
            phase_cnt   <= '0;
            if (!has_bits) begin
              state              <= S_FINISH;
              sweep_done         <= 1'b1;
              busy               <= 1'b0;
              a_input_ring_bit_b <= ALL_ONES;
            end else begin
              state              <= S_LOAD;
              a_input_ring_bit_b <= sel_b;
              counter_load       <= 1'b1;
              stop_b             <= 1'b0;
              counter_enable     <= 1'b0;
              watchdog           <= '0;
            end
          end
        end
        S_LOAD: begin
          counter_load   <= 1'b0;
          stop_b         <= 1'b1;
          counter_enable <= 1'b1;
          state          <= S_RUN;
        end
        S_RUN: begin
          watchdog <= wd_inc;
          // A real done in the same cycle as the watchdog limit is not a timeout.
          if (adder_done || (wd_inc >= wd_limit)) begin
            if (!adder_done) timeout_flags[cur_idx] <= 1'b1;
            stop_b         <= 1'b0;
            counter_enable <= 1'b0;
            phase_cnt      <= '0;
            state          <= S_STOP;
          end
        end
        S_STOP: begin
          phase_cnt <= phase_cnt + 16'd1;
          if (phase_cnt == 16'(SETTLE_CYCLES - 1)) begin
            phase_cnt <= '0;
            state     <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          results[cur_idx] <= ring_count;
          if (!timeout_flags[cur_idx] && (ring_count > max_count)) begin
            max_count <= ring_count;
            max_index <= cur_idx;
          end
          state <= S_NEXT;
        end
        S_NEXT: begin
          if (next_hit[IDX_W]) begin
            cur_idx     <= next_hit[IDX_W-1:0];
            adder_reset <= 1'b1;
            state       <= S_CLEAR;
          end else begin
            state              <= S_FINISH;
            sweep_done         <= 1'b1;
            busy               <= 1'b0;
            a_input_ring_bit_b <= ALL_ONES;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
